// File: rtl/gemm_result_streamer.sv
// Streams a ROWS_RT x COLS_RT sub-block of a row-major GEMM result buffer out of a
// synchronous-read memory as a valid/ready element stream tagged with row/col/eol/last.
//
// state  | meaning
// IDLE   | waiting for start; zero-sized requests answered with a done pulse only
// ISSUE  | walking row-major addresses, issuing reads while FIFO + in-flight < 2
// DRAIN  | all reads issued; waiting for the last element to be accepted
module gemm_result_streamer #(
   parameter int DATA_W = 32,
   parameter int ROWS   = 100,
   parameter int COLS   = 100,
   parameter int ADDR_W = 14,
   parameter int DIM_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  rows_i,
   input  logic [DIM_W-1:0]  cols_i,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DIM_W-1:0]  out_row,
   output logic [DIM_W-1:0]  out_col,
   output logic              out_eol,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   localparam logic [DIM_W-1:0]  ROWS_D = DIM_W'(ROWS);
   localparam logic [DIM_W-1:0]  COLS_D = DIM_W'(COLS);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(COLS);

   state_t            state_q;
   logic [DIM_W-1:0]  rows_q, cols_q, row_q, col_q;
   logic [ADDR_W-1:0] addr_q, base_q;
   logic              busy_q, done_q;

   logic              pend_q, peol_q, plast_q;
   logic [DIM_W-1:0]  prow_q, pcol_q;

   logic [DATA_W-1:0] fdat_q [2];
   logic [DIM_W-1:0]  frow_q [2];
   logic [DIM_W-1:0]  fcol_q [2];
   logic              feol_q [2];
   logic              flast_q [2];
   logic              wr_ptr_q, rd_ptr_q;
   logic [1:0]        cnt_q;

   logic [DIM_W-1:0]  rows_cl, cols_cl;
   logic              issue_eol, issue_last, pop;
   logic [2:0]        occ;

   assign rows_cl    = (rows_i > ROWS_D) ? ROWS_D : rows_i;
   assign cols_cl    = (cols_i > COLS_D) ? COLS_D : cols_i;
   assign issue_eol  = (col_q == cols_q - 1'b1);
   assign issue_last = issue_eol && (row_q == rows_q - 1'b1);

   assign out_valid = (cnt_q != 2'd0);
   assign pop       = out_valid && out_ready;
   // Credit counts a slot being freed this cycle so a steady ready stream has no bubbles.
   assign occ       = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
   assign rd_en     = (state_q == S_ISSUE) && (occ < 3'd2);
   assign rd_addr   = addr_q;

   assign out_data = fdat_q[rd_ptr_q];
   assign out_row  = frow_q[rd_ptr_q];
   assign out_col  = fcol_q[rd_ptr_q];
   assign out_eol  = feol_q[rd_ptr_q];
   assign out_last = flast_q[rd_ptr_q];
   assign busy     = busy_q;
   assign done     = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rows_q     <= '0;
         cols_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         addr_q     <= '0;
         base_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pend_q     <= 1'b0;
         peol_q     <= 1'b0;
         plast_q    <= 1'b0;
         prow_q     <= '0;
         pcol_q     <= '0;
         fdat_q[0]  <= '0;
         fdat_q[1]  <= '0;
         frow_q[0]  <= '0;
         frow_q[1]  <= '0;
         fcol_q[0]  <= '0;
         fcol_q[1]  <= '0;
         feol_q[0]  <= 1'b0;
         feol_q[1]  <= 1'b0;
         flast_q[0] <= 1'b0;
         flast_q[1] <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= 2'd0;
      end else begin
         done_q <= 1'b0;
         pend_q <= rd_en;
         if (rd_en) begin
            prow_q  <= row_q;
            pcol_q  <= col_q;
            peol_q  <= issue_eol;
            plast_q <= issue_last;
         end
         if (pend_q) begin
            fdat_q[wr_ptr_q]  <= rd_data;
            frow_q[wr_ptr_q]  <= prow_q;
            fcol_q[wr_ptr_q]  <= pcol_q;
            feol_q[wr_ptr_q]  <= peol_q;
            flast_q[wr_ptr_q] <= plast_q;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + 2'(pend_q) - 2'(pop);

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  rows_q <= rows_cl;
                  cols_q <= cols_cl;
                  row_q  <= '0;
                  col_q  <= '0;
                  addr_q <= '0;
                  base_q <= '0;
                  if (rows_cl == '0 || cols_cl == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= S_ISSUE;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (rd_en) begin
                  if (issue_eol) begin
                     col_q  <= '0;
                     row_q  <= row_q + 1'b1;
                     base_q <= base_q + STRIDE;
                     addr_q <= base_q + STRIDE;
                  end else begin
                     col_q  <= col_q + 1'b1;
                     addr_q <= addr_q + 1'b1;
                  end
                  if (issue_last) begin
                     state_q <= S_DRAIN;
                     addr_q  <= addr_q;
                  end
               end
            end
            S_DRAIN: begin
               if (pop && out_last) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gemm_result_streamer.sv
// Directed bench for gemm_result_streamer: a table of block requests run through one
// checker, plus hand sequences for mid-block reset and reset-state checks.
module tb_gemm_result_streamer;
   localparam int DATA_W = 32;
   localparam int ROWS   = 100;
   localparam int COLS   = 100;
   localparam int ADDR_W = 14;
   localparam int DIM_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [DIM_W-1:0]  rows_i, cols_i;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid, out_ready;
   logic [DATA_W-1:0] out_data;
   logic [DIM_W-1:0]  out_row, out_col;
   logic              out_eol, out_last, busy, done;

   int total = 0;
   int bad   = 0;

   gemm_result_streamer #(
      .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .DIM_W(DIM_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rows_i(rows_i), .cols_i(cols_i),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_eol(out_eol), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Buffer model: synchronous read, contents tagged by address.
   always @(posedge clk) begin
      if (rd_en) rd_data <= 32'hD000_0000 + 32'(rd_addr);
   end

   task automatic chk(input string nm, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   typedef struct {
      int rin;
      int cin;
      int pct;
      int er;
      int ec;
      int nbeats;
      int last_addr;
      bit dup;
   } vec_t;

   task automatic run_block(input vec_t v);
      int cyc, beats, issued, first_v, dones, done_cyc, last_xfer_cyc;
      int er_c, ec_c, bubbles, stall_err, outst_err, beat_err, busy_bad, extra_err;
      int last_addr_seen, busy_first, busy_at_done, budget;
      bit seen_v, prev_stall, finished;
      logic [65:0] prev_vec, cur_vec;
      logic [DATA_W-1:0] exp_data;
      cyc = 0; beats = 0; issued = 0; first_v = -1; dones = 0; done_cyc = -1;
      last_xfer_cyc = -1; er_c = 0; ec_c = 0; bubbles = 0; stall_err = 0;
      outst_err = 0; beat_err = 0; busy_bad = 0; extra_err = 0; last_addr_seen = -1;
      busy_first = -1; busy_at_done = -1; seen_v = 0; prev_stall = 0; finished = 0;
      prev_vec = '0;
      budget = v.nbeats * 6 + 40;

      @(negedge clk);
      start  = 1'b1;
      rows_i = DIM_W'(v.rin);
      cols_i = DIM_W'(v.cin);
      out_ready = ($urandom_range(0, 99) < v.pct);

      while (!finished && cyc < budget) begin
         @(negedge clk);
         cyc++;
         cur_vec = {out_data, out_row, out_col, out_eol, out_last};
         if (prev_stall && (!out_valid || cur_vec !== prev_vec)) stall_err++;
         if (issued - beats > 2) outst_err++;
         if (cyc == 1) busy_first = int'(busy);
         if (v.nbeats == 0 && busy) busy_bad++;
         if (done) begin
            dones++;
            done_cyc = cyc;
            busy_at_done = int'(busy);
            finished = 1;
         end
         if (out_valid && !seen_v) begin
            seen_v = 1;
            first_v = cyc;
         end
         if (v.pct == 100 && seen_v && beats < v.nbeats && !out_valid) bubbles++;

         start = v.dup && (cyc == 2);
         if (v.dup) begin
            rows_i = 16'd2;
            cols_i = 16'd2;
         end
         out_ready = ($urandom_range(0, 99) < v.pct);
         #1;
         if (rd_en) begin
            issued++;
            last_addr_seen = int'(rd_addr);
         end
         if (out_valid && out_ready) begin
            exp_data = 32'hD000_0000 + 32'(er_c * COLS + ec_c);
            if (out_data !== exp_data || out_row !== DIM_W'(er_c) || out_col !== DIM_W'(ec_c) ||
                out_eol !== (ec_c == v.ec - 1) ||
                out_last !== ((ec_c == v.ec - 1) && (er_c == v.er - 1))) begin
               beat_err++;
               if (beat_err <= 4)
                  $display("FAIL beat r%0d c%0d: got data=%h row=%0d col=%0d eol=%0b last=%0b expected data=%h",
                           er_c, ec_c, out_data, out_row, out_col, out_eol, out_last, exp_data);
            end
            beats++;
            last_xfer_cyc = cyc;
            if (ec_c == v.ec - 1) begin
               ec_c = 0;
               er_c++;
            end else begin
               ec_c++;
            end
            prev_stall = 0;
         end else if (out_valid) begin
            prev_stall = 1;
            prev_vec = cur_vec;
         end else begin
            prev_stall = 0;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done || out_valid || rd_en || busy) extra_err++;
      end

      chk($sformatf("finished_%0dx%0d", v.rin, v.cin), finished, 1);
      chk($sformatf("beats_%0dx%0d", v.rin, v.cin), beats, v.nbeats);
      chk($sformatf("reads_%0dx%0d", v.rin, v.cin), issued, v.nbeats);
      chk($sformatf("done_count_%0dx%0d", v.rin, v.cin), dones, 1);
      chk($sformatf("quiet_after_%0dx%0d", v.rin, v.cin), extra_err, 0);
      if (v.nbeats > 0) begin
         chk($sformatf("beat_order_%0dx%0d", v.rin, v.cin), beat_err, 0);
         chk($sformatf("first_valid_cyc_%0dx%0d", v.rin, v.cin), first_v, 3);
         chk($sformatf("done_after_last_%0dx%0d", v.rin, v.cin), done_cyc, last_xfer_cyc + 1);
         chk($sformatf("last_addr_%0dx%0d", v.rin, v.cin), last_addr_seen, v.last_addr);
         chk($sformatf("stall_hold_%0dx%0d", v.rin, v.cin), stall_err, 0);
         chk($sformatf("outstanding_%0dx%0d", v.rin, v.cin), outst_err, 0);
         chk($sformatf("busy_start_%0dx%0d", v.rin, v.cin), busy_first, 1);
         chk($sformatf("busy_at_done_%0dx%0d", v.rin, v.cin), busy_at_done, 0);
         if (v.pct == 100) chk($sformatf("bubbles_%0dx%0d", v.rin, v.cin), bubbles, 0);
      end else begin
         chk($sformatf("zero_busy_%0dx%0d", v.rin, v.cin), busy_bad, 0);
         chk($sformatf("zero_done_cyc_%0dx%0d", v.rin, v.cin), done_cyc, 1);
         chk($sformatf("zero_no_valid_%0dx%0d", v.rin, v.cin), seen_v, 0);
      end
   endtask

   vec_t vecs [9];

   initial begin
      int beats7, guard;
      vecs[0] = '{rin: 3,   cin: 4,   pct: 100, er: 3,   ec: 4,   nbeats: 12,    last_addr: 203,  dup: 0};
      vecs[1] = '{rin: 5,   cin: 5,   pct: 50,  er: 5,   ec: 5,   nbeats: 25,    last_addr: 404,  dup: 0};
      vecs[2] = '{rin: 0,   cin: 7,   pct: 100, er: 0,   ec: 7,   nbeats: 0,     last_addr: 0,    dup: 0};
      vecs[3] = '{rin: 150, cin: 100, pct: 100, er: 100, ec: 100, nbeats: 10000, last_addr: 9999, dup: 0};
      vecs[4] = '{rin: 1,   cin: 1,   pct: 100, er: 1,   ec: 1,   nbeats: 1,     last_addr: 0,    dup: 0};
      vecs[5] = '{rin: 7,   cin: 0,   pct: 100, er: 7,   ec: 0,   nbeats: 0,     last_addr: 0,    dup: 0};
      vecs[6] = '{rin: 2,   cin: 101, pct: 30,  er: 2,   ec: 100, nbeats: 200,   last_addr: 199,  dup: 0};
      vecs[7] = '{rin: 4,   cin: 1,   pct: 50,  er: 4,   ec: 1,   nbeats: 4,     last_addr: 300,  dup: 0};
      vecs[8] = '{rin: 3,   cin: 3,   pct: 100, er: 3,   ec: 3,   nbeats: 9,     last_addr: 202,  dup: 1};

      rst = 1'b1; start = 1'b0; rows_i = '0; cols_i = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", int'(rd_en | out_valid | busy | done | out_eol | out_last |
          (|out_data) | (|out_row) | (|out_col) | (|rd_addr)), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_block(vecs[i]);

      // Mid-block reset: 4x4, reset after 7 accepted beats, then a fresh 2x2.
      @(negedge clk);
      start = 1'b1; rows_i = 16'd4; cols_i = 16'd4; out_ready = 1'b1;
      beats7 = 0; guard = 0;
      while (beats7 < 7 && guard < 40) begin
         @(negedge clk);
         start = 1'b0;
         guard++;
         #1;
         if (out_valid && out_ready) beats7++;
      end
      chk("midblock_beats", beats7, 7);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midblock_reset_outputs", int'(rd_en | out_valid | busy | done | out_eol | out_last |
          (|out_data) | (|out_row) | (|out_col) | (|rd_addr)), 0);
      @(negedge clk);
      rst = 1'b0;
      run_block('{rin: 2, cin: 2, pct: 100, er: 2, ec: 2, nbeats: 4, last_addr: 101, dup: 0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
